// File: rtl/dsp_be_flag_stat_if.sv
// Bundles the control, flag and statistics signals of dsp_be_flag_stat.
// The i_/o_ prefixes are from the block's point of view.
//   master : drives i_en, i_flag, i_cfg_win_len, i_start, i_clear;
//            observes o_busy, o_done, o_cnt, o_sat
//   slave  : the statistics block itself
interface dsp_be_flag_stat_if #(
    parameter int PRLL_RANK = 64,
    parameter int NUM_FLAGS = 8,
    parameter int CNT_WIDTH = 32,
    parameter int WIN_WIDTH = 32
);
    logic                                  i_en;
    logic [PRLL_RANK-1:0][NUM_FLAGS-1:0]   i_flag;
    logic [WIN_WIDTH-1:0]                  i_cfg_win_len;
    logic                                  i_start;
    logic                                  i_clear;
    logic                                  o_busy;
    logic                                  o_done;
    logic [NUM_FLAGS-1:0][CNT_WIDTH-1:0]   o_cnt;
    logic [NUM_FLAGS-1:0]                  o_sat;

    modport master (
        output i_en, i_flag, i_cfg_win_len, i_start, i_clear,
        input  o_busy, o_done, o_cnt, o_sat
    );
    modport slave (
        input  i_en, i_flag, i_cfg_win_len, i_start, i_clear,
        output o_busy, o_done, o_cnt, o_sat
    );
endinterface

// File: rtl/dsp_be_flag_stat.sv
// Windowed per-flag statistics over PRLL_RANK parallel lanes.
// Each enabled RUN cycle the number of lanes raising each flag is
// registered (stage 1) and then added into a saturating accumulator
// (stage 2). A window ends after i_cfg_win_len enabled samples
// (0 = free-run), followed by one DRAIN cycle that flushes stage 1.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : i_en, i_flag, i_cfg_win_len, i_start, i_clear in;
//                  o_busy, o_done, o_cnt, o_sat out
module dsp_be_flag_stat #(
    parameter int PRLL_RANK = 64,
    parameter int NUM_FLAGS = 8,
    parameter int CNT_WIDTH = 32,
    parameter int WIN_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    dsp_be_flag_stat_if.slave    bus
);
    localparam int PCW = $clog2(PRLL_RANK + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                              r_state, w_next;
    logic                                r_busy, r_done;
    logic [NUM_FLAGS-1:0][PCW-1:0]       w_pc, r_s1;
    logic [NUM_FLAGS-1:0][CNT_WIDTH-1:0] r_acc, w_acc_nxt;
    logic [NUM_FLAGS-1:0]                r_sat, w_ovf;
    logic [WIN_WIDTH-1:0]                r_wcnt, r_win_len, w_wcnt_inc;
    logic [CNT_WIDTH:0]                  w_sum;
    logic                                w_smp, w_start;

    assign w_smp      = (r_state == S_RUN) && bus.i_en;
    assign w_wcnt_inc = r_wcnt + WIN_WIDTH'(1);
    // Start is only honoured from IDLE/DONE, and clear wins over it.
    assign w_start    = bus.i_start && !bus.i_clear &&
                        ((r_state == S_IDLE) || (r_state == S_DONE));

    // Per-flag popcount across lanes.
    always_comb begin
        w_pc = '0;
        for (int f = 0; f < NUM_FLAGS; f++)
            for (int l = 0; l < PRLL_RANK; l++)
                w_pc[f] = w_pc[f] + PCW'(bus.i_flag[l][f]);
    end

    // Saturating add; one extra sum bit detects the clip.
    always_comb begin
        w_acc_nxt = '0;
        w_ovf     = '0;
        w_sum     = '0;
        for (int f = 0; f < NUM_FLAGS; f++) begin
            w_sum = {1'b0, r_acc[f]} + (CNT_WIDTH+1)'(r_s1[f]);
            if (w_sum[CNT_WIDTH]) begin
                w_acc_nxt[f] = '1;
                w_ovf[f]     = 1'b1;
            end else begin
                w_acc_nxt[f] = w_sum[CNT_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (w_start) w_next = S_RUN;
            // Last sample is the one that brings the count to win_len.
            S_RUN:   if (w_smp && (r_win_len != '0) && (w_wcnt_inc == r_win_len))
                         w_next = S_DRAIN;
            S_DRAIN: w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
        if (bus.i_clear) w_next = S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_s1      <= '0;
            r_acc     <= '0;
            r_sat     <= '0;
            r_wcnt    <= '0;
            r_win_len <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == S_RUN) || (w_next == S_DRAIN);
            r_done  <= (w_next == S_DONE);
            if (bus.i_clear) begin
                r_s1   <= '0;
                r_acc  <= '0;
                r_sat  <= '0;
                r_wcnt <= '0;
            end else if (w_start) begin
                r_s1      <= '0;
                r_acc     <= '0;
                r_sat     <= '0;
                r_wcnt    <= '0;
                r_win_len <= bus.i_cfg_win_len;
            end else begin
                r_s1  <= w_smp ? w_pc : '0;
                r_acc <= w_acc_nxt;
                r_sat <= r_sat | w_ovf;
                if (w_smp) r_wcnt <= w_wcnt_inc;
            end
        end
    end

    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;
    assign bus.o_cnt  = r_acc;
    assign bus.o_sat  = r_sat;
endmodule

// File: tb/tb_dsp_be_flag_stat.sv
// Drives a wide-counter instance (CNT_WIDTH=32) and a narrow one
// (CNT_WIDTH=8) with identical random windows. Each window's expected
// totals come from summing lane flags over the enabled samples the window
// admits; a monitor pops them when o_done rises and also checks timing.
module tb_dsp_be_flag_stat;
    localparam int PR = 64;
    localparam int NF = 8;
    localparam int WW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                   en = 1'b0, st = 1'b0, clr = 1'b0;
    logic [PR-1:0][NF-1:0]  flag = '0;
    logic [WW-1:0]          win = '0;

    dsp_be_flag_stat_if #(.PRLL_RANK(PR), .NUM_FLAGS(NF), .CNT_WIDTH(32), .WIN_WIDTH(WW)) ifA();
    dsp_be_flag_stat_if #(.PRLL_RANK(PR), .NUM_FLAGS(NF), .CNT_WIDTH(8),  .WIN_WIDTH(WW)) ifB();

    assign ifA.i_en = en;  assign ifA.i_flag = flag; assign ifA.i_cfg_win_len = win;
    assign ifA.i_start = st; assign ifA.i_clear = clr;
    assign ifB.i_en = en;  assign ifB.i_flag = flag; assign ifB.i_cfg_win_len = win;
    assign ifB.i_start = st; assign ifB.i_clear = clr;

    dsp_be_flag_stat #(.PRLL_RANK(PR), .NUM_FLAGS(NF), .CNT_WIDTH(32), .WIN_WIDTH(WW))
        uA (.i_clk(clk), .i_rst(rst), .bus(ifA));
    dsp_be_flag_stat #(.PRLL_RANK(PR), .NUM_FLAGS(NF), .CNT_WIDTH(8), .WIN_WIDTH(WW))
        uB (.i_clk(clk), .i_rst(rst), .bus(ifB));

    typedef struct {
        logic [NF-1:0][31:0] cnt;
        int unsigned         c0;
        int unsigned         done_cyc;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          vectors = 0;
    int          misc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input longint act, input longint expv);
        vectors++;
        if (act != expv) begin
            misc++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random flags when fi<0, otherwise lanes 0..nl-1 raise flag fi only.
    task automatic gen_flags(input int nl, input int fi);
        for (int l = 0; l < PR; l++)
            for (int f = 0; f < NF; f++)
                flag[l][f] = (fi < 0) ? 1'($urandom) : ((f == fi) && (l < nl));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busyA"}, ifA.o_busy, 0);
        chk({tag, "_doneA"}, ifA.o_done, 0);
        chk({tag, "_busyB"}, ifB.o_busy, 0);
        chk({tag, "_doneB"}, ifB.o_done, 0);
        for (int f = 0; f < NF; f++) begin
            chk({tag, "_cntA"}, ifA.o_cnt[f], 0);
            chk({tag, "_cntB"}, ifB.o_cnt[f], 0);
            chk({tag, "_satA"}, ifA.o_sat[f], 0);
            chk({tag, "_satB"}, ifB.o_sat[f], 0);
        end
    endtask

    // en_mode: 0 always, 1 alternating starting at 1, 2 random (75%).
    task automatic window(input int unsigned wl, input int en_mode, input int nl, input int fi);
        exp_t e;
        int unsigned n = 0;
        int unsigned last = 0;
        e.cnt = '0;
        st = 1'b1; clr = 1'b0; win = wl; en = 1'($urandom); gen_flags(nl, fi);
        e.c0 = cyc;
        tick();
        for (int k = 0; k < 1000; k++) begin
            case (en_mode)
                0:       en = 1'b1;
                1:       en = (k % 2 == 0);
                default: en = ($urandom % 4 != 0);
            endcase
            gen_flags(nl, fi);
            st  = ($urandom % 4 == 0);   // ignored while running
            win = $urandom;              // sampled only at start
            if (en) begin
                n++;
                last = cyc;
                for (int l = 0; l < PR; l++)
                    for (int f = 0; f < NF; f++)
                        e.cnt[f] += 32'(flag[l][f]);
            end
            tick();
            if (en && n == wl) break;
        end
        e.done_cyc = last + 2;
        q.push_back(e);
        // Drain cycle: start and samples here must be ignored.
        st = 1'($urandom); en = 1'($urandom); gen_flags(PR, -1);
        tick();
        st = 1'b0;
        for (int k = 0; k < 12 && q.size() != 0; k++) begin
            en = 1'($urandom); gen_flags(PR, -1);
            tick();
        end
        tick(); tick();
        if (q.size() != 0) begin
            vectors++; misc++;
            $display("FAIL done_timeout @cyc %0d: o_done never rose, expected at cyc %0d",
                     cyc, e.done_cyc);
            q.delete();
        end
    endtask

    // Monitor: compares outputs when o_done rises and while it is held.
    logic pbusy = 1'b0, pdone = 1'b0, holding = 1'b0;
    int unsigned rise = 0, fall = 0;
    exp_t hold_e;

    always @(negedge clk) begin
        if (ifA.o_busy && !pbusy) rise = cyc;
        if (!ifA.o_busy && pbusy) fall = cyc;
        if (ifA.o_done && !pdone) begin
            if (q.size() == 0) begin
                vectors++; misc++;
                $display("FAIL unexpected_done @cyc %0d: o_done=1 with no window pending", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("busy_rise", rise, e.c0 + 1);
                chk("busy_fall", fall, e.done_cyc);
                chk("doneB", ifB.o_done, 1);
                for (int f = 0; f < NF; f++) begin
                    chk($sformatf("cntA[%0d]", f), ifA.o_cnt[f], e.cnt[f]);
                    chk($sformatf("satA[%0d]", f), ifA.o_sat[f], 0);
                    chk($sformatf("cntB[%0d]", f), ifB.o_cnt[f],
                        (e.cnt[f] > 255) ? 255 : e.cnt[f]);
                    chk($sformatf("satB[%0d]", f), ifB.o_sat[f], (e.cnt[f] > 255) ? 1 : 0);
                end
                hold_e  = e;
                holding = 1'b1;
            end
        end else if (ifA.o_done && holding) begin
            for (int f = 0; f < NF; f++)
                chk($sformatf("hold_cntA[%0d]", f), ifA.o_cnt[f], hold_e.cnt[f]);
        end
        if (!ifA.o_done) holding = 1'b0;
        pbusy = ifA.o_busy;
        pdone = ifA.o_done;
    end

    initial begin
        rst = 1'b1;
        tick(); tick();
        chk_idle("reset");
        rst = 1'b0;
        tick();

        window(4, 0, 64, 0);     // 256 on flag0
        window(4, 1, 10, 2);     // alternating enable, 40 on flag2
        window(5, 0, 64, 1);     // narrow counter clips at 255
        window(6, 2, 20, 3);
        for (int i = 0; i < 20; i++)
            window($urandom_range(1, 12), 2, 0, -1);

        // Free-run: 10 enabled cycles, 3 lanes on flag7.
        st = 1'b1; win = '0; en = 1'b0;
        tick();
        st = 1'b0;
        for (int k = 0; k < 10; k++) begin
            en = 1'b1; gen_flags(3, 7);
            tick();
        end
        en = 1'b0; gen_flags(PR, -1);
        tick(); tick(); tick();
        chk("free_busy", ifA.o_busy, 1);
        chk("free_done", ifA.o_done, 0);
        chk("free_cntA7", ifA.o_cnt[7], 30);
        chk("free_cntB7", ifB.o_cnt[7], 30);
        chk("free_cntA0", ifA.o_cnt[0], 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk_idle("free_clear");

        // Clear together with start mid-window.
        st = 1'b1; win = 10; en = 1'b0;
        tick();
        st = 1'b0;
        for (int k = 0; k < 3; k++) begin
            en = 1'b1; gen_flags(PR, -1);
            tick();
        end
        clr = 1'b1; st = 1'b1;
        tick();
        clr = 1'b0; st = 1'b0; en = 1'b0;
        chk_idle("clr_start");
        tick();
        chk("clr_start_stay_busy", ifA.o_busy, 0);

        // Reset in the third RUN cycle, then a fresh window.
        st = 1'b1; win = 8;
        tick();
        st = 1'b0;
        for (int k = 0; k < 3; k++) begin
            en = 1'b1; gen_flags(PR, -1);
            if (k == 2) rst = 1'b1;
            tick();
        end
        rst = 1'b0; en = 1'b0;
        chk_idle("rst_mid_run");
        tick();
        window(4, 0, 64, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end
endmodule
